// File: rtl/bcm_matrix_driver.sv
// Column-scan LED matrix driver. Each column's pixels are shifted out once per bit-plane, and
// each plane is displayed for a time proportional to its binary weight (BCM), with global dimming.
module bcm_matrix_driver #(
    parameter int NUM_COLS = 16,
    parameter int ROW_BITS = 64,
    parameter int PIXEL_W  = 8,
    parameter int DIM_W    = 8,
    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int ADDR_W  = (NUM_COLS * ROW_BITS > 1) ? $clog2(NUM_COLS * ROW_BITS) : 1
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_hold,
    input  logic [DIM_W-1:0]  dim,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [PIXEL_W-1:0] pix_data,
    output logic [COL_W-1:0]  cols,
    output logic              sclk,
    output logic              sdi,
    output logic              le,
    output logic              oe,
    output logic              frame_done,
    output logic              busy
);

    localparam int PLANE_W = (PIXEL_W > 1) ? $clog2(PIXEL_W) : 1;
    localparam int SHOW_W  = PIXEL_W + DIM_W;
    localparam int SH_W    = $clog2(2 * ROW_BITS + 1);

    localparam logic [SH_W-1:0]    SH_LAST      = SH_W'(2 * ROW_BITS);
    localparam logic [SH_W-1:0]    SH_LAST_ADDR = SH_W'(2 * ROW_BITS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST   = PLANE_W'(PIXEL_W - 1);
    localparam logic [COL_W-1:0]   COL_LAST     = COL_W'(NUM_COLS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_SHOW  = 2'd3;

    logic [1:0]         state_reg;
    logic [COL_W-1:0]   col_reg;
    logic [PLANE_W-1:0] plane_reg;
    logic [SH_W-1:0]    sh_cnt_reg;
    logic [SHOW_W-1:0]  show_cnt_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DIM_W-1:0]   dim_reg;
    logic               sdi_reg;
    logic               frame_done_reg;

    // Last SHOW count for each plane: (2**b << DIM_W) - 1.
    logic [SHOW_W-1:0] show_last_tbl [PIXEL_W];
    logic [SHOW_W-1:0] show_last;

    for (genvar gi = 0; gi < PIXEL_W; gi++) begin : g_slot_len
        assign show_last_tbl[gi] = SHOW_W'((64'(1) << (gi + DIM_W)) - 64'(1));
    end

    assign show_last = show_last_tbl[plane_reg];

    function automatic logic [ADDR_W-1:0] col_base(input logic [COL_W-1:0] c);
        return ADDR_W'(int'(c) * ROW_BITS);
    endfunction

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            col_reg        <= '0;
            plane_reg      <= '0;
            sh_cnt_reg     <= '0;
            show_cnt_reg   <= '0;
            addr_reg       <= '0;
            dim_reg        <= '0;
            sdi_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (enable && !frame_hold) begin
                        state_reg  <= S_SHIFT;
                        col_reg    <= '0;
                        plane_reg  <= '0;
                        sh_cnt_reg <= '0;
                        addr_reg   <= col_base('0);
                    end
                end
                S_SHIFT: begin
                    // Odd counts are the sclk-low cycles; the bit shown there is held through the high cycle.
                    if (sh_cnt_reg[0]) begin
                        sdi_reg <= pix_data[plane_reg];
                    end
                    if (sh_cnt_reg[0] && (sh_cnt_reg < SH_LAST_ADDR)) begin
                        addr_reg <= addr_reg + 1'b1;
                    end
                    if (sh_cnt_reg == SH_LAST) begin
                        state_reg <= S_LATCH;
                    end else begin
                        sh_cnt_reg <= sh_cnt_reg + 1'b1;
                    end
                end
                S_LATCH: begin
                    state_reg    <= S_SHOW;
                    show_cnt_reg <= '0;
                    dim_reg      <= dim;
                end
                S_SHOW: begin
                    show_cnt_reg <= show_cnt_reg + 1'b1;
                    if (show_cnt_reg == show_last) begin
                        sh_cnt_reg <= '0;
                        if (plane_reg != PLANE_LAST) begin
                            plane_reg <= plane_reg + 1'b1;
                            addr_reg  <= col_base(col_reg);
                            state_reg <= S_SHIFT;
                        end else begin
                            plane_reg <= '0;
                            if (col_reg != COL_LAST) begin
                                col_reg   <= col_reg + 1'b1;
                                addr_reg  <= col_base(col_reg + 1'b1);
                                state_reg <= S_SHIFT;
                            end else begin
                                frame_done_reg <= 1'b1;
                                if (frame_hold || !enable) begin
                                    state_reg <= S_IDLE;
                                end else begin
                                    col_reg   <= '0;
                                    addr_reg  <= col_base('0);
                                    state_reg <= S_SHIFT;
                                end
                            end
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // pix_data arrives in the low cycle itself, so sdi passes it straight through there.
    assign sdi        = (state_reg == S_SHIFT && sh_cnt_reg[0]) ? pix_data[plane_reg] : sdi_reg;
    assign sclk       = (state_reg == S_SHIFT) && !sh_cnt_reg[0] && (sh_cnt_reg != '0);
    assign le         = (state_reg == S_LATCH);
    assign oe         = (state_reg == S_SHOW) && (show_cnt_reg[DIM_W-1:0] < dim_reg);
    assign busy       = (state_reg != S_IDLE);
    assign pix_addr   = addr_reg;
    assign cols       = col_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_bcm_matrix_driver.sv
// Bench for bcm_matrix_driver: a monitor rebuilds each displayed slot and compares it against
// slot records queued when each frame is requested.
module tb_bcm_matrix_driver;

    localparam int NUM_COLS  = 2;
    localparam int ROW_BITS  = 4;
    localparam int PIXEL_W   = 2;
    localparam int DIM_W     = 2;
    localparam int COL_W     = 1;
    localparam int ADDR_W    = 3;
    localparam int FRAME_LEN = NUM_COLS * (PIXEL_W * (2 * ROW_BITS + 2) + (((1 << PIXEL_W) - 1) << DIM_W));

    logic               clk_50 = 1'b0;
    logic               reset;
    logic               enable;
    logic               frame_hold;
    logic [DIM_W-1:0]   dim;
    logic [ADDR_W-1:0]  pix_addr;
    logic [PIXEL_W-1:0] pix_data;
    logic [COL_W-1:0]   cols;
    logic               sclk, sdi, le, oe, frame_done, busy;

    bcm_matrix_driver #(
        .NUM_COLS(NUM_COLS), .ROW_BITS(ROW_BITS), .PIXEL_W(PIXEL_W), .DIM_W(DIM_W)
    ) dut (
        .clk_50(clk_50), .reset(reset), .enable(enable), .frame_hold(frame_hold), .dim(dim),
        .pix_addr(pix_addr), .pix_data(pix_data), .cols(cols), .sclk(sclk), .sdi(sdi),
        .le(le), .oe(oe), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk_50 = ~clk_50;

    // Frame memory with a one-cycle registered read.
    logic [PIXEL_W-1:0] mem [NUM_COLS*ROW_BITS];
    always @(posedge clk_50) pix_data <= mem[pix_addr];

    typedef struct {
        int                  col;
        int                  plane;
        logic [ROW_BITS-1:0] word;
        int                  oe_on;
        int                  len;
        bit                  last;
    } slot_t;

    typedef struct {
        int pattern;
        int dim_val;
        int oe_p0;
        int oe_p1;
        int nframes;
    } tc_t;

    slot_t exp_q[$];
    slot_t cur;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    fd_seen = 0;
    int    last_fd = -1;
    int    cyc = 0;
    bit    mon_en = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic fill_mem(input int pattern);
        for (int a = 0; a < NUM_COLS * ROW_BITS; a++) begin
            logic [ADDR_W-1:0] av;
            av = ADDR_W'(a);
            case (pattern)
                0:       mem[a] = av[PIXEL_W-1:0];
                1:       mem[a] = PIXEL_W'($urandom);
                default: mem[a] = ~av[PIXEL_W-1:0];
            endcase
        end
    endtask

    task automatic push_frame(input int oe0, input int oe1);
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int p = 0; p < PIXEL_W; p++) begin
                slot_t s;
                logic [PIXEL_W-1:0] px;
                s.col = c;
                s.plane = p;
                for (int i = 0; i < ROW_BITS; i++) begin
                    px = mem[c * ROW_BITS + i];
                    s.word[i] = px[p];
                end
                s.oe_on = (p == 0) ? oe0 : oe1;
                s.len   = (1 << p) << DIM_W;
                s.last  = (c == NUM_COLS - 1) && (p == PIXEL_W - 1);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic wait_fd(input int target, input int budget);
        int k;
        k = 0;
        while (fd_seen < target && k < budget) begin
            @(negedge clk_50);
            k++;
        end
        if (fd_seen < target) chk("frame_done_timeout", fd_seen, target);
    endtask

    task automatic run_frames(input int n, input int oe0, input int oe1);
        int base;
        base = fd_seen;
        last_fd = -1;
        for (int f = 0; f < n; f++) push_frame(oe0, oe1);
        enable = 1'b1;
        if (n > 1) wait_fd(base + n - 1, 2 * FRAME_LEN * n);
        else tick();
        enable = 1'b0;
        wait_fd(base + n, 3 * FRAME_LEN);
        repeat (3) tick();
        chk("idle_busy", int'(busy), 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: rebuilds shifted words, counts oe per slot, checks frame_done and ghosting.
    int                  rise_cnt;
    logic [ROW_BITS-1:0] shift_word;
    int                  win_left;
    int                  oe_acc;
    bit                  post_chk;
    logic                prev_sclk, prev_sdi;
    logic [COL_W-1:0]    prev_cols;

    initial forever begin
        @(negedge clk_50);
        if (reset || !mon_en) begin
            rise_cnt   = 0;
            shift_word = '0;
            win_left   = 0;
            oe_acc     = 0;
            post_chk   = 0;
            prev_sclk  = 0;
            prev_sdi   = 0;
            prev_cols  = cols;
        end else begin
            cyc++;
            if (cols !== prev_cols) chk("cols_change_oe", int'(oe), 0);
            prev_cols = cols;
            if (sclk && !prev_sclk) begin
                chk("sdi_hold", int'(sdi), int'(prev_sdi));
                if (rise_cnt < ROW_BITS) shift_word[rise_cnt] = sdi;
                rise_cnt++;
            end
            if (frame_done) fd_seen++;
            if (post_chk) begin
                post_chk = 0;
                chk("frame_done", int'(frame_done), int'(cur.last));
                if (frame_done && last_fd >= 0) chk("frame_period", cyc - last_fd, FRAME_LEN);
                if (frame_done) last_fd = cyc;
            end else if (frame_done) begin
                chk("stray_frame_done", 1, 0);
            end
            if (win_left > 0) begin
                if (oe) oe_acc++;
                win_left--;
                if (win_left == 0) begin
                    chk("oe_cycles", oe_acc, cur.oe_on);
                    post_chk = 1;
                end
            end else begin
                chk("oe_off", int'(oe), 0);
            end
            if (le) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_le", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    $display("slot col=%0d plane=%0d word=%h rises=%0d", cols, cur.plane, shift_word, rise_cnt);
                    chk("slot_col", int'(cols), cur.col);
                    chk("sclk_rises", rise_cnt, ROW_BITS);
                    chk("row_word", int'(shift_word), int'(cur.word));
                    win_left = cur.len;
                    oe_acc = 0;
                end
                rise_cnt = 0;
                shift_word = '0;
            end
            prev_sclk = sclk;
            prev_sdi  = sdi;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    tc_t tcs [4];

    initial begin
        int base;
        int k;
        tcs[0] = '{pattern: 0, dim_val: 3, oe_p0: 3, oe_p1: 6, nframes: 1};
        tcs[1] = '{pattern: 0, dim_val: 2, oe_p0: 2, oe_p1: 4, nframes: 2};
        tcs[2] = '{pattern: 1, dim_val: 0, oe_p0: 0, oe_p1: 0, nframes: 1};
        tcs[3] = '{pattern: 2, dim_val: 1, oe_p0: 1, oe_p1: 2, nframes: 2};

        reset = 1'b1;
        enable = 1'b0;
        frame_hold = 1'b0;
        dim = '0;
        fill_mem(0);
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset with enable low.
        repeat (8) begin
            @(negedge clk_50);
            chk("reset_outputs", int'({cols, pix_addr, sclk, sdi, le, oe, frame_done}), 0);
            chk("reset_busy", int'(busy), 0);
        end

        mon_en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            fill_mem(tcs[t].pattern);
            dim = DIM_W'(tcs[t].dim_val);
            $display("case %0d: pattern=%0d dim=%0d frames=%0d", t, tcs[t].pattern, tcs[t].dim_val, tcs[t].nframes);
            run_frames(tcs[t].nframes, tcs[t].oe_p0, tcs[t].oe_p1);
        end

        // Hold raised mid-frame: frame finishes, then stays dark until hold drops.
        fill_mem(0);
        dim = 2'd3;
        base = fd_seen;
        last_fd = -1;
        push_frame(3, 6);
        enable = 1'b1;
        repeat (20) tick();
        frame_hold = 1'b1;
        wait_fd(base + 1, 3 * FRAME_LEN);
        repeat (4) begin
            @(negedge clk_50);
            chk("hold_busy", int'(busy), 0);
            chk("hold_oe", int'(oe), 0);
        end
        last_fd = -1;
        push_frame(3, 6);
        frame_hold = 1'b0;
        tick();
        enable = 1'b0;
        wait_fd(base + 2, 3 * FRAME_LEN);
        repeat (3) tick();
        chk("hold_restart_idle", int'(busy), 0);
        chk("hold_queue_empty", exp_q.size(), 0);

        // Reset during SHOW aborts the scan at once.
        mon_en = 1'b0;
        @(negedge clk_50);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        k = 0;
        while (!le && k < 100) begin
            @(negedge clk_50);
            k++;
        end
        chk("abort_le_seen", int'(le), 1);
        tick();
        chk("abort_in_show_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        @(negedge clk_50);
        chk("abort_busy", int'(busy), 0);
        chk("abort_oe", int'(oe), 0);
        chk("abort_outputs", int'({cols, pix_addr, sclk, le, frame_done}), 0);
        reset = 1'b0;
        tick();
        mon_en = 1'b1;
        run_frames(1, 3, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
